// File: rtl/mem_bridge_if.sv
// Memory bus between mem_bridge (master) and the external 16-bit memory (slave).
// req/ack handshake: address, write data and direction are held stable while req is high.
interface mem_bridge_if;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_we;
    logic        bus_req;
    logic [15:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_addr, bus_wdata, bus_we, bus_req,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_we, bus_req,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_bridge.sv
// Datapath-to-memory bridge: one req/ack bus transaction per microcode read/write command.
// Optional REQ timeout/abort path is built when MEM_BRIDGE_TIMEOUT_EN is defined.
module mem_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_start,
    input  logic                wr_start,
    input  logic [15:0]         mar,
    input  logic [15:0]         mdr,
    output logic [15:0]         mdrin,
    output logic                rc,
    output logic                busy,
    output logic                done,
    output logic                err,
    mem_bridge_if.master        bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_mdrin;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_we;
    logic        r_req;
    logic        r_rc;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic        w_start_one;
    logic        w_start_both;

    assign w_start_one  = rd_start ^ wr_start;
    assign w_start_both = rd_start & wr_start;

`ifdef MEM_BRIDGE_TIMEOUT_EN
    logic [7:0]  r_cnt;
    logic        w_timeout;

    // Abort on the REQ cycle that would bring the no-ack count up to TIMEOUT.
    assign w_timeout = (r_cnt == 8'(TIMEOUT - 32'd1));
`else
    logic        w_unused_timeout;
    assign w_unused_timeout = ^8'(TIMEOUT);
`endif

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mdrin <= 16'h0000;
            r_addr  <= 16'h0000;
            r_wdata <= 16'h0000;
            r_we    <= 1'b0;
            r_req   <= 1'b0;
            r_rc    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
            r_cnt   <= 8'd0;
`endif
        end else begin
            r_rc   <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_req  <= 1'b0;
                    r_busy <= 1'b0;
                    if (w_start_one) begin
                        r_addr  <= mar;
                        r_wdata <= mdr;
                        r_we    <= wr_start;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
`ifdef MEM_BRIDGE_TIMEOUT_EN
                        r_cnt   <= 8'd0;
`endif
                        r_state <= ST_REQ;
                    end else if (w_start_both) begin
                        r_err <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus.bus_ack) begin
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_rc    <= ~r_we;
                        if (!r_we) begin
                            r_mdrin <= bus.bus_rdata;
                        end
                        r_state <= ST_RESP;
`ifdef MEM_BRIDGE_TIMEOUT_EN
                    end else if (w_timeout) begin
                        // Reads still load a defined MDR value on abort.
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_rc    <= ~r_we;
                        if (!r_we) begin
                            r_mdrin <= 16'hFFFF;
                        end
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
`endif
                    end
                end
                ST_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mdrin         = r_mdrin;
    assign rc            = r_rc;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign bus.bus_addr  = r_addr;
    assign bus.bus_wdata = r_wdata;
    assign bus.bus_we    = r_we;
    assign bus.bus_req   = r_req;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed self-checking bench for mem_bridge with a response scoreboard.
// Timeout scenario runs when MEM_BRIDGE_TIMEOUT_EN is defined (TIMEOUT = 4).
module tb_mem_bridge;

    logic        clk;
    logic        rst;
    logic        rd_start;
    logic        wr_start;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic [15:0] mdrin;
    logic        rc;
    logic        busy;
    logic        done;
    logic        err;

    mem_bridge_if bus_if ();

    mem_bridge #(.TIMEOUT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_start (rd_start),
        .wr_start (wr_start),
        .mar      (mar),
        .mdr      (mdr),
        .mdrin    (mdrin),
        .rc       (rc),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bus      (bus_if.master)
    );

    typedef struct packed {
        logic        rc;
        logic        err;
        logic [15:0] mdrin;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for done, then compare against the oldest expected response.
    task automatic wait_resp(input string tag, input int budget);
        exp_t e;
        int   n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_done"}, {15'd0, done}, 16'd1);
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_rc"},    {15'd0, rc},  {15'd0, e.rc});
            chk({tag, "_err"},   {15'd0, err}, {15'd0, e.err});
            chk({tag, "_mdrin"}, mdrin,        e.mdrin);
        end
    endtask

    initial begin
        int n;
        rst               = 1'b1;
        rd_start          = 1'b0;
        wr_start          = 1'b0;
        mar               = 16'h0000;
        mdr               = 16'h0000;
        bus_if.bus_ack    = 1'b0;
        bus_if.bus_rdata  = 16'h0000;
        step();
        step();
        rst = 1'b0;
        chk("rst_mdrin", mdrin, 16'h0000);
        chk("rst_addr",  bus_if.bus_addr, 16'h0000);
        chk("rst_ctl",   {11'd0, bus_if.bus_we, bus_if.bus_req, rc, done, err}, 16'h0000);
        chk("rst_busy",  {15'd0, busy}, 16'd0);

        // Read, ack after 3 REQ cycles; a second start while busy is ignored.
        mar = 16'h0123;
        rd_start = 1'b1;
        sb.push_back('{rc: 1'b1, err: 1'b0, mdrin: 16'hBEEF});
        step();
        rd_start = 1'b0;
        chk("rd_req1", {15'd0, bus_if.bus_req}, 16'd1);
        chk("rd_busy", {15'd0, busy}, 16'd1);
        chk("rd_addr", bus_if.bus_addr, 16'h0123);
        chk("rd_we",   {15'd0, bus_if.bus_we}, 16'd0);
        mar = 16'h9999;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        chk("rd_req2", {15'd0, bus_if.bus_req}, 16'd1);
        step();
        chk("rd_req3", {15'd0, bus_if.bus_req}, 16'd1);
        chk("rd_addr_hold", bus_if.bus_addr, 16'h0123);
        chk("rd_ignored_err", {15'd0, err}, 16'd0);
        bus_if.bus_rdata = 16'hBEEF;
        bus_if.bus_ack   = 1'b1;
        step();
        bus_if.bus_ack = 1'b0;
        chk("rd_req_fall", {15'd0, bus_if.bus_req}, 16'd0);
        chk("rd_busy_resp", {15'd0, busy}, 16'd1);
        wait_resp("rd", 0);
        step();
        chk("rd_busy_low", {15'd0, busy}, 16'd0);
        chk("rd_done_low", {15'd0, done}, 16'd0);
        chk("rd_no_restart", {15'd0, bus_if.bus_req}, 16'd0);

        // Write with zero-wait ack, followed by a read at the earliest legal point.
        mar = 16'h0040;
        mdr = 16'h5A5A;
        wr_start = 1'b1;
        bus_if.bus_ack = 1'b1;
        bus_if.bus_rdata = 16'h7777;
        sb.push_back('{rc: 1'b0, err: 1'b0, mdrin: 16'hBEEF});
        step();
        wr_start = 1'b0;
        chk("wr_we",    {15'd0, bus_if.bus_we}, 16'd1);
        chk("wr_wdata", bus_if.bus_wdata, 16'h5A5A);
        chk("wr_addr",  bus_if.bus_addr, 16'h0040);
        chk("wr_done_early", {15'd0, done}, 16'd0);
        step();
        bus_if.bus_ack = 1'b0;
        wait_resp("wr", 0);
        step();
        chk("wr_busy_low", {15'd0, busy}, 16'd0);
        mar = 16'h0200;
        rd_start = 1'b1;
        bus_if.bus_ack = 1'b1;
        bus_if.bus_rdata = 16'h1234;
        sb.push_back('{rc: 1'b1, err: 1'b0, mdrin: 16'h1234});
        step();
        rd_start = 1'b0;
        chk("b2b_req",  {15'd0, bus_if.bus_req}, 16'd1);
        chk("b2b_addr", bus_if.bus_addr, 16'h0200);
        step();
        bus_if.bus_ack = 1'b0;
        wait_resp("b2b", 0);
        step();

        // Simultaneous read and write command in IDLE.
        rd_start = 1'b1;
        wr_start = 1'b1;
        step();
        rd_start = 1'b0;
        wr_start = 1'b0;
        chk("ill_err",  {15'd0, err}, 16'd1);
        chk("ill_done", {15'd0, done}, 16'd0);
        chk("ill_req",  {15'd0, bus_if.bus_req}, 16'd0);
        chk("ill_busy", {15'd0, busy}, 16'd0);
        step();
        chk("ill_err_pulse", {15'd0, err}, 16'd0);
        chk("ill_req2", {15'd0, bus_if.bus_req}, 16'd0);

        // Reset in the middle of a pending read; a late ack must be ignored.
        mar = 16'h0777;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_mdrin", mdrin, 16'h0000);
        chk("mid_rst_addr",  bus_if.bus_addr, 16'h0000);
        chk("mid_rst_wdata", bus_if.bus_wdata, 16'h0000);
        chk("mid_rst_ctl",   {11'd0, bus_if.bus_we, bus_if.bus_req, rc, done, err}, 16'h0000);
        chk("mid_rst_busy",  {15'd0, busy}, 16'd0);
        bus_if.bus_rdata = 16'hDEAD;
        bus_if.bus_ack   = 1'b1;
        step();
        step();
        bus_if.bus_ack = 1'b0;
        chk("late_ack_ctl",   {13'd0, rc, done, bus_if.bus_req}, 16'h0000);
        chk("late_ack_mdrin", mdrin, 16'h0000);

        // Start in the same cycle as reset is discarded.
        rst = 1'b1;
        rd_start = 1'b1;
        step();
        rst = 1'b0;
        rd_start = 1'b0;
        step();
        chk("rst_start_req",  {15'd0, bus_if.bus_req}, 16'd0);
        chk("rst_start_busy", {15'd0, busy}, 16'd0);

`ifdef MEM_BRIDGE_TIMEOUT_EN
        // Read with no ack: abort after TIMEOUT REQ cycles.
        mar = 16'h0010;
        rd_start = 1'b1;
        sb.push_back('{rc: 1'b1, err: 1'b1, mdrin: 16'hFFFF});
        step();
        rd_start = 1'b0;
        n = 0;
        while (bus_if.bus_req === 1'b1 && n < 20) begin
            n++;
            step();
        end
        chk("to_req_cycles", 16'(n), 16'd4);
        wait_resp("to", 0);
        step();
        chk("to_busy_low", {15'd0, busy}, 16'd0);
`else
        // Without the timeout path REQ waits for ack indefinitely.
        mar = 16'h0010;
        rd_start = 1'b1;
        sb.push_back('{rc: 1'b1, err: 1'b0, mdrin: 16'h4242});
        step();
        rd_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
        end
        chk("nto_req",  {15'd0, bus_if.bus_req}, 16'd1);
        chk("nto_busy", {15'd0, busy}, 16'd1);
        chk("nto_err",  {14'd0, err, done}, 16'd0);
        bus_if.bus_rdata = 16'h4242;
        bus_if.bus_ack   = 1'b1;
        step();
        bus_if.bus_ack = 1'b0;
        wait_resp("nto", 0);
        step();
`endif

        n = 0;
        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
